// File: rtl/uart_reg_bridge.sv
// Byte-level command responder: decodes UART read/write commands for a 128 x 8 register
// space, drives a simple register bus and returns one response byte per command.
module uart_reg_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       srst_n,
    input  logic [7:0] rx_value,
    input  logic       rx_value_ready,
    output logic [7:0] tx_value,
    output logic       tx_value_write,
    input  logic       tx_value_done,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_write,
    output logic       reg_read,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       err_timeout,
    output logic       err_overrun
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StGetData,
        StBusWr,
        StBusRd,
        StRdCap,
        StSend,
        StWaitDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [6:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      resp_q, resp_d;
    logic            timeout_d;
    logic            overrun_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        resp_d    = resp_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rx_value_ready) begin
                    addr_d  = rx_value[6:0];
                    state_d = rx_value[7] ? StGetData : StBusRd;
                end
            end
            StGetData: begin
                cnt_d = cnt_q + CntW'(1);
                // A byte arriving in the final waiting cycle takes priority over the timeout.
                if (rx_value_ready) begin
                    wdata_d = rx_value;
                    state_d = StBusWr;
                end else if (cnt_q == CntLast) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StBusWr: begin
                resp_d  = wdata_q;
                state_d = StSend;
            end
            StBusRd: state_d = StRdCap;
            StRdCap: begin
                resp_d  = reg_rdata;
                state_d = StSend;
            end
            StSend: state_d = StWaitDone;
            StWaitDone: begin
                if (tx_value_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        overrun_d = rx_value_ready && (state_q != StIdle) && (state_q != StGetData);
    end

    // Strobes are decoded from the next state so every output leaves a flop.
    always_ff @(posedge clock) begin
        if (!srst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            resp_q         <= '0;
            reg_write      <= 1'b0;
            reg_read       <= 1'b0;
            tx_value_write <= 1'b0;
            busy           <= 1'b0;
            err_timeout    <= 1'b0;
            err_overrun    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            resp_q         <= resp_d;
            reg_write      <= (state_d == StBusWr);
            reg_read       <= (state_d == StBusRd);
            tx_value_write <= (state_d == StSend);
            busy           <= (state_d != StIdle);
            err_timeout    <= timeout_d;
            err_overrun    <= overrun_d;
        end
    end

    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign tx_value  = resp_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: stimulus pushes expected bus/tx/error events with
// their cycle numbers, a negedge monitor pops and compares them as the DUT produces them.
module tb_uart_reg_bridge;

    localparam int unsigned T = 16;

    logic       clock = 1'b0;
    logic       srst_n;
    logic [7:0] rx_value;
    logic       rx_value_ready;
    logic [7:0] tx_value;
    logic       tx_value_write;
    logic       tx_value_done;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_write;
    logic       reg_read;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       err_timeout;
    logic       err_overrun;

    uart_reg_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clock         (clock),
        .srst_n        (srst_n),
        .rx_value      (rx_value),
        .rx_value_ready(rx_value_ready),
        .tx_value      (tx_value),
        .tx_value_write(tx_value_write),
        .tx_value_done (tx_value_done),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_write     (reg_write),
        .reg_read      (reg_read),
        .reg_rdata     (reg_rdata),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .err_overrun   (err_overrun)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         cyc;
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t q_tx[$];
    exp_t q_wr[$];
    exp_t q_rd[$];
    int   q_to[$];
    int   q_ov[$];

    logic [7:0] mem[128];      // register slave contents
    logic [7:0] ref_mem[128];  // reference model of what the registers should hold
    int done_min = 1;
    int done_max = 6;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event seen, none expected (cycle %0d)", name, cyc);
    endtask

    task automatic check_zero(input string name);
        check(name, {3'b0, tx_value, tx_value_write, reg_addr, reg_wdata, reg_write, reg_read,
                     busy, err_timeout, err_overrun}, 32'h0);
    endtask

    // Register slave: read data valid the cycle after the strobe.
    always @(posedge clock) begin
        if (reg_read) reg_rdata <= mem[reg_addr];
        if (reg_write) mem[reg_addr] <= reg_wdata;
    end

    // Monitor
    exp_t e_mon;
    int   c_mon;
    always @(negedge clock) begin
        if (tx_value_write) begin
            if (q_tx.size() == 0) fail_event("tx_unexpected");
            else begin
                e_mon = q_tx.pop_front();
                check("tx_data", 32'(tx_value), 32'(e_mon.data));
                check("tx_cycle", cyc, e_mon.cyc);
            end
        end
        if (reg_write) begin
            if (q_wr.size() == 0) fail_event("wr_unexpected");
            else begin
                e_mon = q_wr.pop_front();
                check("wr_addr", 32'(reg_addr), 32'(e_mon.addr));
                check("wr_data", 32'(reg_wdata), 32'(e_mon.data));
                check("wr_cycle", cyc, e_mon.cyc);
            end
        end
        if (reg_read) begin
            if (q_rd.size() == 0) fail_event("rd_unexpected");
            else begin
                e_mon = q_rd.pop_front();
                check("rd_addr", 32'(reg_addr), 32'(e_mon.addr));
                check("rd_cycle", cyc, e_mon.cyc);
            end
        end
        if (err_timeout) begin
            if (q_to.size() == 0) fail_event("timeout_unexpected");
            else begin
                c_mon = q_to.pop_front();
                check("timeout_cycle", cyc, c_mon);
            end
        end
        if (err_overrun) begin
            if (q_ov.size() == 0) fail_event("overrun_unexpected");
            else begin
                c_mon = q_ov.pop_front();
                check("overrun_cycle", cyc, c_mon);
            end
        end
    end

    // UART transmitter model: completes each requested byte after a delay.
    int d_done;
    always begin
        @(negedge clock);
        if (tx_value_write) begin
            d_done = $urandom_range(done_max, done_min);
            repeat (d_done) @(posedge clock);
            #1 tx_value_done = 1'b1;
            @(posedge clock);
            #1 tx_value_done = 1'b0;
            @(negedge clock);
            check("busy_after_done", 32'(busy), 32'h0);
        end
    end

    task automatic send_byte(input logic [7:0] b, output int c);
        @(posedge clock);
        #1;
        rx_value       = b;
        rx_value_ready = 1'b1;
        c              = cyc;
        @(posedge clock);
        #1 rx_value_ready = 1'b0;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] dat, input int gap);
        int c;
        int m;
        send_byte({1'b1, a}, c);
        repeat (gap) @(posedge clock);
        send_byte(dat, m);
        q_wr.push_back('{cyc: m + 1, addr: a, data: dat});
        q_tx.push_back('{cyc: m + 2, addr: a, data: dat});
        ref_mem[a] = dat;
    endtask

    task automatic do_read(input logic [6:0] a);
        int n;
        send_byte({1'b0, a}, n);
        q_rd.push_back('{cyc: n + 1, addr: a, data: 8'h0});
        q_tx.push_back('{cyc: n + 3, addr: a, data: ref_mem[a]});
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while ((busy || tx_value_done) && k < 300);
        if (k >= 300) fail_event("idle_wait_expired");
    endtask

    task automatic wait_done_pulse();
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!tx_value_done && k < 300);
        if (k >= 300) fail_event("done_wait_expired");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g;
        logic [6:0] a;
        srst_n         = 1'b0;
        rx_value       = 8'h0;
        rx_value_ready = 1'b0;
        tx_value_done  = 1'b0;
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero("reset_outputs");
        @(posedge clock);
        #1 srst_n = 1'b1;

        // Write then read of a known register
        do_write(7'h05, 8'h3C, 2);
        wait_idle();
        mem[7'h12]     = 8'hA7;
        ref_mem[7'h12] = 8'hA7;
        do_read(7'h12);
        wait_idle();

        // Timeout: GET_DATA lasts T cycles, pulse the cycle after
        send_byte(8'h81, n);
        q_to.push_back(n + T + 1);
        repeat (20) @(posedge clock);
        do_read(7'h01);
        wait_idle();
        // Data byte in the very last waiting cycle is accepted
        do_write(7'h01, 8'hE4, T - 2);
        wait_idle();

        // Overrun while the response is outstanding
        done_min = 10;
        done_max = 10;
        do_read(7'h02);
        repeat ($urandom_range(0, 4)) @(posedge clock);
        send_byte(8'h55, n);
        q_ov.push_back(n + 1);
        wait_idle();

        // Reset while waiting for write data
        done_min = 1;
        done_max = 6;
        send_byte(8'h81, n);
        repeat (3) @(posedge clock);
        #1 srst_n = 1'b0;
        @(posedge clock);
        #1 srst_n = 1'b1;
        @(negedge clock);
        check_zero("reset_in_get_data");
        repeat (T + 4) @(posedge clock);

        // Reset while waiting for tx completion; the late done must be ignored
        done_min = 8;
        done_max = 8;
        do_read(7'h33);
        g = 0;
        do begin
            @(negedge clock);
            g++;
        end while (!tx_value_write && g < 20);
        if (g >= 20) fail_event("tx_wait_expired");
        @(posedge clock);
        #1 srst_n = 1'b0;
        @(posedge clock);
        #1 srst_n = 1'b1;
        @(negedge clock);
        check_zero("reset_in_wait_done");
        repeat (12) @(posedge clock);
        @(negedge clock);
        check("busy_after_stale_done", 32'(busy), 32'h0);
        done_min = 1;
        done_max = 6;
        do_write(7'h10, 8'h11, 1);
        wait_idle();

        // Back-to-back: next command in the cycle right after done
        do_write(7'h00, 8'h42, 0);
        wait_done_pulse();
        do_read(7'h00);
        wait_done_pulse();
        wait_idle();

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 7)) : 7'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom), $urandom_range(0, T - 2));
            else do_read(a);
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end

        repeat (30) @(posedge clock);
        check("tx_queue_drained", 32'(q_tx.size()), 32'h0);
        check("wr_queue_drained", 32'(q_wr.size()), 32'h0);
        check("rd_queue_drained", 32'(q_rd.size()), 32'h0);
        check("timeout_queue_drained", 32'(q_to.size()), 32'h0);
        check("overrun_queue_drained", 32'(q_ov.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Byte-level command responder sitting on the user side of `simple_uart`: it consumes received bytes (`rx_value` / `rx_value_ready`), decodes read/write commands for a 128 x 8-bit register space, drives a simple register bus, and returns one response byte per command through the UART transmit handshake (`tx_value` / `tx_value_write` / `tx_value_done`). It lets a host PC peek/poke on-chip registers over the serial link.

## Interface

- `TIMEOUT_CYCLES`, 50000, max clock cycles spent waiting for a write data byte (10 byte times at 100 kbaud / 50 MHz); legal range >= 2.
- `clock` in 1: system clock, all logic on rising edge.
- `srst_n` in 1: synchronous reset, active-low.
- `rx_value` in 8: received byte, valid when `rx_value_ready`=1.
- `rx_value_ready` in 1: one-cycle pulse per received byte.
- `tx_value` out 8: response byte to transmit.
- `tx_value_write` out 1: one-cycle pulse requesting transmission of `tx_value`.
- `tx_value_done` in 1: one-cycle pulse when the UART has finished sending the byte.
- `reg_addr` out 7: register address.
- `reg_wdata` out 8: register write data.
- `reg_write` out 1: one-cycle write strobe.
- `reg_read` out 1: one-cycle read strobe.
- `reg_rdata` in 8: read data, valid exactly one cycle after `reg_read`.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `err_timeout` out 1: one-cycle pulse when a write command is abandoned.
- `err_overrun` out 1: one-cycle pulse when a received byte is dropped.

## Operation

- Command byte: bit 7 = 1 write, 0 read; bits [6:0] = address. Write is followed by one data byte. Each completed command returns one byte: read -> register content, write -> echo of written data.
- States: IDLE, GET_DATA, BUS_WR, BUS_RD, RD_CAP, SEND, WAIT_DONE.
- IDLE: on `rx_value_ready`, latch `reg_addr` <= `rx_value[6:0]`; bit7=1 -> GET_DATA, else -> BUS_RD.
- GET_DATA: timeout counter (width `$clog2(TIMEOUT_CYCLES+1)`) cleared on entry, increments each cycle. On `rx_value_ready`, latch `reg_wdata` -> BUS_WR. If no byte and counter == `TIMEOUT_CYCLES-1` -> IDLE with `err_timeout`. A byte in that same last cycle wins (accepted, no error).
- BUS_WR: `reg_write`=1 for this cycle; response register <= `reg_wdata` -> SEND.
- BUS_RD: `reg_read`=1 for this cycle -> RD_CAP.
- RD_CAP: response register <= `reg_rdata` -> SEND.
- SEND: `tx_value_write`=1 for this cycle, `tx_value` = response register -> WAIT_DONE.
- WAIT_DONE: hold `tx_value` stable; on `tx_value_done` -> IDLE.
- `rx_value_ready` in any state other than IDLE/GET_DATA: byte dropped, `err_overrun` pulsed the next cycle; FSM unaffected.
- `tx_value_done` outside WAIT_DONE is ignored (covers stale completion after reset).
- `reg_addr` / `reg_wdata` hold last latched values between commands.

## Timing

- All outputs registered. Reset (`srst_n`=0 sampled at an edge): state IDLE, all outputs 0 (`tx_value`, `reg_addr`, `reg_wdata` = 0, all strobes, `busy`, error pulses = 0), counter cleared. Reset mid-command aborts silently; no response byte is sent.
- Write: data byte in cycle M -> `reg_write` at M+1 -> `tx_value_write` at M+2.
- Read: command byte in cycle N -> `reg_read` at N+1 -> `reg_rdata` sampled at N+2 -> `tx_value_write` at N+3.
- `tx_value_done` in cycle D -> IDLE at D+1; a command byte in D+1 is accepted.
- `busy` = 1 from the cycle after command acceptance through the cycle of `tx_value_done`.
- `err_timeout` asserted the cycle after the final GET_DATA cycle; GET_DATA lasts exactly `TIMEOUT_CYCLES` cycles.
- `err_overrun` asserted the cycle after the dropped byte's `rx_value_ready`.

## Test plan

- Write: rx 0x85 (cycle N), 0x3C (cycle M) -> `reg_write` at M+1 with `reg_addr`=0x05, `reg_wdata`=0x3C; `tx_value_write` at M+2 with `tx_value`=0x3C; `busy` low the cycle after `tx_value_done`.
- Read: register model holds 0xA7 at 0x12; rx 0x12 at N -> `reg_read` at N+1, `tx_value`=0xA7 with `tx_value_write` at N+3; no `reg_write`.
- Timeout: rx 0x81, then no byte for `TIMEOUT_CYCLES` (bench uses 16) -> `err_timeout` one pulse, no `reg_write`, no tx; next byte 0x01 is decoded as a read of 0x01. Repeat with data byte on cycle 16 exactly -> accepted, no error.
- Overrun: rx 0x02, then 0x55 while in WAIT_DONE -> `err_overrun` one pulse, exactly one response byte, 0x55 never written.
- Reset: assert `srst_n`=0 in GET_DATA and in WAIT_DONE -> all outputs 0 next cycle; stale `tx_value_done` after release ignored; following write 0x90/0x11 completes normally.
- Back-to-back via `simple_uart` loop at 100 kbaud: host sends 0x80,0x42 then 0x00 -> responses 0x42 then 0x42 in order, no error pulses.
